rom_loader: RTL
===============

Name: rom_loader

Overview:
- Upstream feeder for the 64 KB boot ROM's loader write port.
- Accepts a byte stream from the MCU/SPI receive path over a valid/ready handshake.
- Parses a 2-byte start address, then writes each following data byte to consecutive ROM addresses.
- Drives loader_act, loader_a, loader_d and loader_wr, and reports a byte count and a running checksum so firmware can confirm the image.

Parameters:
- ADDR_W, 16, ROM address width; the address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a new load session
- stop  in  1  one-cycle pulse; ends the session
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  block can accept a byte
- loader_act  out  1  load session active; ROM write path owned by loader
- loader_a  out  ADDR_W  ROM write address
- loader_d  out  8  ROM write data
- loader_wr  out  1  one-cycle ROM write strobe
- byte_cnt  out  17  data bytes written this session
- checksum  out  16  running checksum of data bytes
- addr_wrap  out  1  sticky: address wrapped past max this session
- done  out  1  one-cycle pulse at session end

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state IDLE
  - all outputs 0, except checksum = init value
  - any pending write is dropped
- States: IDLE, ADDR_HI, ADDR_LO, DATA, DONE.
- Handshake:
  - A byte transfers on a cycle where in_valid & in_ready.
  - in_ready = 1 in ADDR_HI, ADDR_LO and DATA; 0 in IDLE and DONE.
- start in any state:
  - next state ADDR_HI
  - byte_cnt, addr_wrap and checksum cleared/initialised
  - a write already registered still issues
- ADDR_HI: accepted byte loads addr[15:8]; next state ADDR_LO.
- ADDR_LO: accepted byte loads addr[7:0]; next state DATA.
- DATA, each accepted byte at cycle N:
  - cycle N+1: loader_wr=1, loader_a=addr, loader_d=byte
  - addr increments; byte_cnt increments, saturating at 17'h1FFFF
  - checksum updates
- Address wrap: addr 0xFFFF increments to 0x0000 and sets addr_wrap (sticky until next start or reset).
- stop:
  - In ADDR_HI, ADDR_LO or DATA, next state is DONE.
  - A byte accepted in the same cycle as stop is still processed (written if in DATA).
  - stop in IDLE or DONE is ignored.
  - start and stop in the same cycle: start wins.
- DONE: done=1 for exactly one cycle, then IDLE.
- loader_act:
  - Registered.
  - 1 from the cycle after start until the cycle after done.
  - Always 1 during any loader_wr pulse.
- After a session, byte_cnt, checksum and addr_wrap hold their values until the next start or reset.
- Reset mid-session: no further loader_wr pulses; bytes already written stay in the ROM.
- Latency: in-data to loader_wr is 1 cycle. Throughput is 1 byte/cycle with no backpressure in DATA.

Optional Feature:
- ROM_LOADER_CRC16_EN defined:
  - checksum = CRC-16/CCITT-FALSE over data bytes (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR).
  - CRC updates a byte per cycle, combinationally unrolled.
- Undefined:
  - checksum[7:0] = 8-bit additive sum mod 256 of data bytes, init 0x00; checksum[15:8] = 0.
- Address bytes never enter the checksum in either mode.

Test Plan:
- Reset then idle -> loader_act=0, loader_wr=0, in_ready=0, byte_cnt=0. checksum=0xFFFF with the macro defined, 0x0000 without.
- start; bytes 0x12,0x34,0xAA,0x55 back-to-back; stop -> two loader_wr pulses (0x1234←0xAA, 0x1235←0x55), each one cycle after acceptance. byte_cnt=2; additive checksum=0xFF; done pulses once; loader_act drops the cycle after done.
- start; address 0xFFFF; data 0x01,0x02 -> writes at 0xFFFF then 0x0000; addr_wrap=1; byte_cnt=2.
- CRC build: start; address 0x0000; ASCII "123456789"; stop -> checksum=0x29B1, byte_cnt=9.
- start; address 0x0100; random in_valid gaps, 3 bytes; stop coincident with the 3rd byte's acceptance -> all 3 written at 0x0100–0x0102; done 1 cycle after that stop.
- start; address 0x0000; 2 data bytes written, then start again -> byte_cnt=0 and checksum reinitialised; new address parsed. Separately, rst_n=0 mid-DATA -> no write pulses from the first cycle of reset.

Source files
------------

// File: rtl/rom_loader.sv
// Byte-stream loader for the boot ROM write port: 2-byte big-endian start address, then data bytes.
// Define ROM_LOADER_CRC16_EN for a CRC-16/CCITT-FALSE checksum; otherwise an 8-bit additive sum.
module rom_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              loader_act,
    output logic [ADDR_W-1:0] loader_a,
    output logic [7:0]        loader_d,
    output logic              loader_wr,
    output logic [16:0]       byte_cnt,
    output logic [15:0]       checksum,
    output logic              addr_wrap,
    output logic              done,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on any cycle with in_valid & in_ready; in_ready depends only on state.
    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, DONE} state_t;

`ifdef ROM_LOADER_CRC16_EN
    localparam logic [15:0] CS_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`else
    localparam logic [15:0] CS_INIT = 16'h0000;
`endif

    state_t            state, state_next;
    logic [7:0]        addr_hi;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic [15:0]       cs_next;

    assign dbg_state = state;

    always_comb begin
        state_next = state;
        in_ready   = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
        accept     = in_valid && in_ready;
        done       = (state == DONE);
`ifdef ROM_LOADER_CRC16_EN
        cs_next    = crc16_byte(checksum, in_data);
`else
        cs_next    = {8'h00, checksum[7:0] + in_data};
`endif
        if (start) begin
            state_next = ADDR_HI;
        end else begin
            case (state)
                ADDR_HI: if (stop) state_next = DONE; else if (accept) state_next = ADDR_LO;
                ADDR_LO: if (stop) state_next = DONE; else if (accept) state_next = DATA;
                DATA:    if (stop) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_hi    <= 8'h00;
            addr       <= '0;
            loader_act <= 1'b0;
            loader_a   <= '0;
            loader_d   <= 8'h00;
            loader_wr  <= 1'b0;
            byte_cnt   <= 17'd0;
            checksum   <= CS_INIT;
            addr_wrap  <= 1'b0;
        end else begin
            state      <= state_next;
            loader_act <= (state_next != IDLE);
            loader_wr  <= 1'b0;
            // start wins over any byte presented in the same cycle; that byte is discarded.
            if (start) begin
                byte_cnt  <= 17'd0;
                checksum  <= CS_INIT;
                addr_wrap <= 1'b0;
            end else if (accept) begin
                case (state)
                    ADDR_HI: addr_hi <= in_data;
                    ADDR_LO: addr    <= ADDR_W'({addr_hi, in_data});
                    DATA: begin
                        loader_wr <= 1'b1;
                        loader_a  <= addr;
                        loader_d  <= in_data;
                        addr      <= addr + ADDR_W'(1);
                        checksum  <= cs_next;
                        if (addr == '1) addr_wrap <= 1'b1;
                        if (byte_cnt != 17'h1FFFF) byte_cnt <= byte_cnt + 17'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
